// File: rtl/t_ff_updown_counter.sv
// Modulo-N up/down counter built from one T flip-flop per bit.
// Per-bit toggle enables are derived from the count, direction, enable and load.
module t_ff_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] next;

    // '>=' rather than '==' so an out-of-range loaded value wraps to 0 on the next up step.
    assign at_top    = (q >= LAST);
    assign at_bottom = (q == '0);

    // NOTE: next gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next = q;
        if (rst) begin
            next = '0;
        end else if (load) begin
            next = d;
        end else if (en) begin
            if (up) begin
                next = at_top ? '0 : q + WIDTH'(1);
            end else begin
                next = at_bottom ? LAST : q - WIDTH'(1);
            end
        end
    end

    assign t_vec = q ^ next;
    assign qbar  = ~q;
    assign tc    = ~rst & en & ~load & (up ? at_top : at_bottom);

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q ^ t_vec;
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_t_ff_updown_counter.sv
// Directed bench for t_ff_updown_counter: a binary (mod-16) and a mod-10 instance,
// with expected values queued on a scoreboard as stimulus is applied.
module tb_t_ff_updown_counter;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] d;
    } stim_t;

    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    logic  clk = 1'b0;
    stim_t sa;
    stim_t sb;

    logic [3:0] q_a, qbar_a, t_vec_a, q_b, qbar_b, t_vec_b;
    logic       tc_a, wrap_a, tc_b, wrap_b;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    t_ff_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
        .clk(clk), .rst(sa.rst), .en(sa.en), .up(sa.up), .load(sa.load), .d(sa.d),
        .q(q_a), .qbar(qbar_a), .t_vec(t_vec_a), .tc(tc_a), .wrap(wrap_a)
    );

    t_ff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk(clk), .rst(sb.rst), .en(sb.en), .up(sb.up), .load(sb.load), .d(sb.d),
        .q(q_b), .qbar(qbar_b), .t_vec(t_vec_b), .tc(tc_b), .wrap(wrap_b)
    );

    task automatic expect_val(input string tag, input logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [3:0] obs);
        exp_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: got %0h with nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sa = '{rst: 1'b1, en: 1'b1, up: 1'b1, load: 1'b1, d: 4'hA};
        sb = '{rst: 1'b1, en: 1'b1, up: 1'b1, load: 1'b1, d: 4'hA};
        #1;
        expect_val("rst_tc_pre_a", 4'h0); check({3'b0, tc_a});

        // Reset dominates load and enable for two cycles.
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_val("rst_q_a",    4'h0); check(q_a);
            expect_val("rst_qbar_a", 4'hF); check(qbar_a);
            expect_val("rst_wrap_a", 4'h0); check({3'b0, wrap_a});
            expect_val("rst_tc_a",   4'h0); check({3'b0, tc_a});
            expect_val("rst_tvec_a", 4'h0); check(t_vec_a);
            expect_val("rst_q_b",    4'h0); check(q_b);
            expect_val("rst_tvec_b", 4'h0); check(t_vec_b);
        end

        // Binary up count through the wrap.
        sa = '{rst: 1'b0, en: 1'b1, up: 1'b1, load: 1'b0, d: 4'h0};
        sb = '{rst: 1'b0, en: 1'b0, up: 1'b1, load: 1'b0, d: 4'h0};
        #1;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] cur;
            logic [3:0] nxt;
            cur = 4'(i % 16);
            nxt = 4'((i + 1) % 16);
            expect_val("up_q",    cur);                      check(q_a);
            expect_val("up_qbar", ~cur);                     check(qbar_a);
            expect_val("up_tc",   {3'b0, cur == 4'hF});      check({3'b0, tc_a});
            expect_val("up_tvec", cur ^ nxt);                check(t_vec_a);
            tick();
            expect_val("up_wrap", {3'b0, cur == 4'hF});      check({3'b0, wrap_a});
        end

        // Mod-10 down wrap from 0.
        sb = '{rst: 1'b0, en: 1'b1, up: 1'b0, load: 1'b0, d: 4'h0};
        #1;
        expect_val("dn_tvec_at0", 4'h9); check(t_vec_b);
        expect_val("dn_tc_at0",   4'h1); check({3'b0, tc_b});
        tick();
        expect_val("dn_q_wrap",   4'h9); check(q_b);
        expect_val("dn_wrap",     4'h1); check({3'b0, wrap_b});

        // Load beats enable; out-of-range value held as loaded.
        sb = '{rst: 1'b0, en: 1'b1, up: 1'b1, load: 1'b1, d: 4'd12};
        #1;
        expect_val("ld_tc",    4'h0); check({3'b0, tc_b});
        expect_val("ld_tvec",  4'h9 ^ 4'd12); check(t_vec_b);
        tick();
        expect_val("ld_q",     4'd12); check(q_b);
        expect_val("ld_wrap",  4'h0); check({3'b0, wrap_b});
        sb.load = 1'b0;
        #1;
        expect_val("oor_up_tc",   4'h1); check({3'b0, tc_b});
        expect_val("oor_up_tvec", 4'd12); check(t_vec_b);
        tick();
        expect_val("oor_up_q",    4'h0); check(q_b);
        expect_val("oor_up_wrap", 4'h1); check({3'b0, wrap_b});

        // Out-of-range value counting down decrements normally.
        sb = '{rst: 1'b0, en: 1'b1, up: 1'b0, load: 1'b1, d: 4'd12};
        tick();
        expect_val("oor_ld2_q",   4'd12); check(q_b);
        sb.load = 1'b0;
        #1;
        expect_val("oor_dn_tc",   4'h0); check({3'b0, tc_b});
        tick();
        expect_val("oor_dn_q",    4'd11); check(q_b);
        expect_val("oor_dn_wrap", 4'h0); check({3'b0, wrap_b});

        // Direction flip with no dead cycle, then enable gating.
        sb = '{rst: 1'b0, en: 1'b0, up: 1'b1, load: 1'b1, d: 4'd0};
        tick();
        sb = '{rst: 1'b0, en: 1'b1, up: 1'b1, load: 1'b0, d: 4'd0};
        repeat (5) tick();
        expect_val("flip_up5", 4'd5); check(q_b);
        sb.up = 1'b0;
        tick();
        expect_val("flip_first", 4'd4); check(q_b);
        repeat (2) tick();
        expect_val("flip_dn3", 4'd2); check(q_b);
        sb.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_val("hold_tvec", 4'h0); check(t_vec_b);
            expect_val("hold_tc",   4'h0); check({3'b0, tc_b});
            tick();
            expect_val("hold_q",    4'd2); check(q_b);
        end

        // Reset on the wrap edge suppresses the wrap pulse.
        sa = '{rst: 1'b0, en: 1'b1, up: 1'b1, load: 1'b1, d: 4'hF};
        tick();
        expect_val("mr_ld_q", 4'hF); check(q_a);
        sa.load = 1'b0;
        #1;
        expect_val("mr_tc_pre", 4'h1); check({3'b0, tc_a});
        sa.rst = 1'b1;
        #1;
        expect_val("mr_tc_rst", 4'h0); check({3'b0, tc_a});
        tick();
        expect_val("mr_q",    4'h0); check(q_a);
        expect_val("mr_wrap", 4'h0); check({3'b0, wrap_a});
        sa = '{rst: 1'b0, en: 1'b0, up: 1'b1, load: 1'b0, d: 4'h0};
        tick();
        expect_val("mr_wrap_after", 4'h0); check({3'b0, wrap_a});
        expect_val("mr_q_after",    4'h0); check(q_a);

        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
